// File: rtl/matmul_job_arbiter_if.sv
// matmul_job_arbiter_if: requester/FSMD-facing bundle of the matmul job arbiter
interface matmul_job_arbiter_if;
  logic [1:0] req;
  logic       ld_out_i;
  logic [7:0] res_i;
  logic       go_o;
  logic [1:0] gnt;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_data;
  logic [3:0] res_idx;
  logic [1:0] done;
  logic       timeout;
  modport master (
    output req, ld_out_i, res_i,
    input  go_o, gnt, busy, res_valid, res_data, res_idx, done, timeout
  );
  modport slave (
    input  req, ld_out_i, res_i,
    output go_o, gnt, busy, res_valid, res_data, res_idx, done, timeout
  );
endinterface

// File: rtl/matmul_job_arbiter.sv
// matmul_job_arbiter: round-robin arbitration of two requesters onto one matmul FSMD,
// forwarding indexed results and aborting jobs that exceed a RUN-cycle budget.
module matmul_job_arbiter #(
  parameter int N_RESULTS   = 9,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                 CLK,
  input logic                 RST,
  matmul_job_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pend_q, pend_d;
  logic          abort_q, abort_d;
  logic          last_res, tmo;
  always_comb begin
    last_res = pend_q && cnt_q == 4'(N_RESULTS - 1);
    tmo      = tcnt_q == TW'(TIMEOUT_CYC - 1);
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: state_d = |bus.req ? ARB : IDLE;
      ARB: begin
        // last_q holds the index of the previous winner; the other bit wins contention
        gnt_d   = (bus.req == 2'b10 || (bus.req == 2'b11 && !last_q)) ? 2'b10 : 2'b01;
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        tcnt_d  = '0;
        abort_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        tcnt_d  = tcnt_q + TW'(1);
        cnt_d   = pend_q ? cnt_q + 4'd1 : cnt_q;
        state_d = (last_res || tmo) ? FIN : RUN;
        abort_d = tmo && !last_res;
      end
      FIN: begin
        last_d  = gnt_q[1];
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a strobe only becomes a result if RUN continues into the presentation cycle
    pend_d = state_q == RUN && state_d == RUN && bus.ld_out_i;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
    end
  end
  assign bus.go_o      = state_q == START;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.res_valid = pend_q;
  assign bus.res_data  = pend_q ? bus.res_i : '0;
  assign bus.res_idx   = pend_q ? cnt_q : '0;
  assign bus.done      = state_q == FIN ? gnt_q : '0;
  assign bus.timeout   = state_q == FIN && abort_q;
endmodule
